// File: rtl/ram_led_pwm.sv
// LED PWM driver fed from a block of dual-port RAM words, scanned periodically and committed atomically.
// Optional macro RAM_LED_PWM_EN enables true PWM; without it each LED follows bit 0 of its duty word.
module ram_led_pwm #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int LED_COUNT  = 4,
    parameter int BASE_ADDR  = 0,
    parameter int PWM_BITS   = 8,
    parameter int SCAN_DIV   = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ram_cs_n,
    output logic                  ram_we_n,
    output logic                  ram_oe_n,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [LED_COUNT-1:0]  led,
    output logic                  scan_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(LED_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ        = 2'd1,
        CAPTURE     = 2'd2,
        WAIT_COMMIT = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [IDX_W-1:0]    idx_r;
    logic [IDX_W-1:0]    idx_next_s;
    logic [DIV_W-1:0]    div_r;
    logic                tick_s;
    logic                pwm_wrap_s;
    logic                commit_s;
    logic [PWM_BITS-1:0] shadow_r [LED_COUNT];
    logic [PWM_BITS-1:0] duty_r   [LED_COUNT];
    logic                unused_data_s;

    // Only the low PWM_BITS of each word carry duty information.
    assign unused_data_s = ^ram_data;

    assign tick_s   = (div_r == DIV_LAST);
    assign commit_s = (state_r == WAIT_COMMIT) && pwm_wrap_s;

    // Scan-start divider, wraps every SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

`ifdef RAM_LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_r;

    // Free-running PWM period counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_r <= '0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
        end
    end

    // Committing on the last count lets new duties start exactly at the wrap to 0.
    assign pwm_wrap_s = &pwm_cnt_r;
`else
    assign pwm_wrap_s = 1'b1;
`endif

    // FSM state and word index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Next-state logic; ticks outside IDLE are simply ignored.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    idx_next_s   = '0;
                    state_next_s = READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ: begin
                state_next_s = CAPTURE;
            end
            CAPTURE: begin
                if (idx_r == IDX_LAST) begin
                    state_next_s = WAIT_COMMIT;
                end else begin
                    idx_next_s   = idx_r + IDX_W'(1);
                    state_next_s = READ;
                end
            end
            WAIT_COMMIT: begin
                if (commit_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_COMMIT;
                end
            end
            default: begin
                state_next_s = IDLE;
                idx_next_s   = '0;
            end
        endcase
    end

    // RAM strobes are registered from the next state so they coincide with READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_cs_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
            ram_addr <= '0;
        end else begin
            ram_cs_n <= (state_next_s != READ);
            ram_oe_n <= (state_next_s != READ);
            ram_we_n <= 1'b1;
            if (state_next_s == READ) begin
                ram_addr <= BASE + ADDR_WIDTH'(idx_next_s);
            end else begin
                ram_addr <= ram_addr;
            end
        end
    end

    // Shadow copies collect a scan; duties change only on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LED_COUNT; i++) begin
                shadow_r[i] <= '0;
                duty_r[i]   <= '0;
            end
            scan_done <= 1'b0;
        end else begin
            for (int i = 0; i < LED_COUNT; i++) begin
                if ((state_r == CAPTURE) && (idx_r == IDX_W'(i))) begin
                    shadow_r[i] <= ram_data[PWM_BITS-1:0];
                end else begin
                    shadow_r[i] <= shadow_r[i];
                end
                if (commit_s) begin
                    duty_r[i] <= shadow_r[i];
                end else begin
                    duty_r[i] <= duty_r[i];
                end
            end
            scan_done <= commit_s;
        end
    end

`ifdef RAM_LED_PWM_EN
    // Full-scale duty is forced on so the LED never blinks off at the top count.
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else begin
            for (int i = 0; i < LED_COUNT; i++) begin
                if (&duty_r[i]) begin
                    led[i] <= 1'b1;
                end else begin
                    led[i] <= (pwm_cnt_r < duty_r[i]);
                end
            end
        end
    end
`else
    logic unused_duty_s;

    // Without PWM, upper duty bits have no effect.
    always_comb begin
        unused_duty_s = 1'b0;
        for (int i = 0; i < LED_COUNT; i++) begin
            unused_duty_s = unused_duty_s ^ (^duty_r[i]);
        end
    end

    // On/off drive from bit 0 of each committed duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else begin
            for (int i = 0; i < LED_COUNT; i++) begin
                led[i] <= duty_r[i][0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_led_pwm.sv
// Directed bench for ram_led_pwm: reset, scan addressing, commit timing, LED drive; two instances (base 0 and base 14).
module tb_ram_led_pwm;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int LC    = 4;
    localparam int PB    = 8;
    localparam int SD    = 64;
    localparam int BOUND = 600;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs_n, we_n, oe_n, done;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata = '0;
    logic [LC-1:0] led;
    logic          cs_n_w, we_n_w, oe_n_w, done_w;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] rdata_w = '0;
    logic [LC-1:0] led_w;
    logic [DW-1:0] mem [16];

    int passed = 0;
    int total  = 0;
    int addr_q[$];
    int addr_w_q[$];
    int led_q[$];

    always #5 clk = ~clk;

    // One-cycle read latency RAM models.
    always @(posedge clk) begin
        if (!cs_n && !oe_n) rdata <= mem[addr];
        if (!cs_n_w && !oe_n_w) rdata_w <= mem[addr_w];
    end

    ram_led_pwm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LED_COUNT(LC), .BASE_ADDR(0),
                  .PWM_BITS(PB), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .ram_cs_n(cs_n), .ram_we_n(we_n), .ram_oe_n(oe_n),
        .ram_addr(addr), .ram_data(rdata), .led(led), .scan_done(done));

    ram_led_pwm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LED_COUNT(LC), .BASE_ADDR(14),
                  .PWM_BITS(PB), .SCAN_DIV(SD)) dut_w (
        .clk(clk), .rst(rst), .ram_cs_n(cs_n_w), .ram_we_n(we_n_w), .ram_oe_n(oe_n_w),
        .ram_addr(addr_w), .ram_data(rdata_w), .led(led_w), .scan_done(done_w));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic reset_outputs_check(input string pfx);
        check({pfx, "_cs_n"}, 32'(cs_n), 32'd1);
        check({pfx, "_oe_n"}, 32'(oe_n), 32'd1);
        check({pfx, "_we_n"}, 32'(we_n), 32'd1);
        check({pfx, "_addr"}, 32'(addr), 32'd0);
        check({pfx, "_led"}, 32'(led), 32'd0);
        check({pfx, "_done"}, 32'(done), 32'd0);
        check({pfx, "_w_cs_n"}, 32'(cs_n_w), 32'd1);
        check({pfx, "_w_led"}, 32'(led_w), 32'd0);
    endtask

    task automatic push_scan_addrs();
        for (int i = 0; i < LC; i++) begin
            addr_q.push_back(i);
            addr_w_q.push_back((14 + i) % 16);
        end
    endtask

    // Waits for the next scan, checks its READ cycles, returns at the scan_done sample.
    task automatic scan_check(input string pfx, output int waited);
        int  lows, edges, dones, cyc;
        logic prev;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (cs_n !== 1'b0 && waited < BOUND);
        lows = 0; edges = 0; dones = 0; cyc = 0; prev = 1'b1;
        while (dones == 0 && cyc < BOUND) begin
            if (cs_n === 1'b0) begin
                lows++;
                if (prev === 1'b1) edges++;
                check({pfx, "_oe_n"}, 32'(oe_n), 32'd0);
                check({pfx, "_w_cs_n"}, 32'(cs_n_w), 32'd0);
                if (addr_q.size() > 0) check({pfx, "_addr"}, 32'(addr), 32'(addr_q.pop_front()));
                if (addr_w_q.size() > 0) check({pfx, "_w_addr"}, 32'(addr_w), 32'(addr_w_q.pop_front()));
            end
            if (done === 1'b1) dones++;
            prev = cs_n;
            if (dones == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        check({pfx, "_read_cycles"}, 32'(lows), 32'(LC));
        check({pfx, "_read_pulses"}, 32'(edges), 32'(LC));
        check({pfx, "_scan_done"}, 32'(dones), 32'd1);
        check({pfx, "_addrs_left"}, 32'(addr_q.size()), 32'd0);
        check({pfx, "_we_n"}, 32'(we_n), 32'd1);
    endtask

    initial begin : main
        int w;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[1]  = 16'h0040;
        mem[2]  = 16'h0080;
        mem[3]  = 16'h00FF;
        mem[14] = 16'hFF01;
        mem[15] = 16'h0100;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_outputs_check("por");
        rst = 1'b0;

        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (cs_n !== 1'b0 && w < BOUND);
        check("first_scan_start", 32'(w), 32'(SD));

        // Abort the scan in progress.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_outputs_check("midscan_rst");
        rst = 1'b0;

        push_scan_addrs();
        scan_check("scan1", w);
        check("rst_to_scan", 32'(w), 32'(SD));
`ifndef RAM_LED_PWM_EN
        begin : onoff
            led_q.push_back(4'b1000);
            led_q.push_back(4'b0001);
            led_q.push_back(4'b1100);
            check("led_at_commit", 32'(led), 32'd0);
            @(negedge clk);
            check("done_width", 32'(done), 32'd0);
            check("led_after_commit", 32'(led), 32'(led_q.pop_front()));
            check("led_w_after_commit", 32'(led_w), 32'(led_q.pop_front()));

            mem[2] = 16'h0003;
            push_scan_addrs();
            scan_check("scan2", w);
            check("led2_before_on", 32'(led[2]), 32'd0);
            @(negedge clk);
            check("led_word2_3", 32'(led), 32'(led_q.pop_front()));

            mem[2] = 16'h0002;
            push_scan_addrs();
            scan_check("scan3", w);
            check("led2_before_off", 32'(led[2]), 32'd1);
            @(negedge clk);
            check("led2_word2_2", 32'(led[2]), 32'd0);
        end
`else
        begin : pwm
            int hi [LC];
            int hi_w [LC];
            int c;
            led_q.push_back(0);   led_q.push_back(64); led_q.push_back(128); led_q.push_back(256);
            led_q.push_back(1);   led_q.push_back(0);  led_q.push_back(0);   led_q.push_back(64);
            for (int i = 0; i < LC; i++) begin
                hi[i] = 0;
                hi_w[i] = 0;
            end
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                for (int i = 0; i < LC; i++) begin
                    hi[i] += int'(led[i]);
                    hi_w[i] += int'(led_w[i]);
                end
            end
            for (int i = 0; i < LC; i++) check($sformatf("led%0d_high", i), 32'(hi[i]), 32'(led_q.pop_front()));
            for (int i = 0; i < LC; i++) check($sformatf("led_w%0d_high", i), 32'(hi_w[i]), 32'(led_q.pop_front()));

            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (done !== 1'b1 && c < BOUND);
            check("wait_commit", 32'(done), 32'd1);
            mem[1] = 16'h0020;
            hi[1] = 0;
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                hi[1] += int'(led[1]);
            end
            check("glitch_old_high", 32'(hi[1]), 32'd64);
            check("glitch_commit_at_wrap", 32'(done), 32'd1);
            hi[1] = 0;
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                hi[1] += int'(led[1]);
            end
            check("glitch_new_high", 32'(hi[1]), 32'd32);
        end
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_led_pwm.md
# ram_led_pwm

Read-side consumer for port 1 of the dual-port RAM that the GPMC controller writes from the ARM. Periodically scans a block of consecutive RAM words, one per LED, and drives each LED with a PWM duty cycle taken from the low bits of its word. New duty values are applied together at a PWM period boundary, so a scan never produces a partial or glitched update.

## Interface
Parameters:
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 4, RAM address width
- LED_COUNT, 4, number of LED outputs and words scanned (1..2^ADDR_WIDTH)
- BASE_ADDR, 0, RAM address of the LED 0 word; LED i reads BASE_ADDR+i
- PWM_BITS, 8, duty resolution (≤ DATA_WIDTH)
- SCAN_DIV, 2048, clk cycles between scan starts (≥ 2*LED_COUNT+2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ram_cs_n  out  1  RAM port chip select, active low
- ram_we_n  out  1  RAM port write enable, active low; tied high (read-only)
- ram_oe_n  out  1  RAM port output enable, active low
- ram_addr  out  ADDR_WIDTH  RAM port address
- ram_data  in  DATA_WIDTH  RAM port read data
- led  out  LED_COUNT  PWM LED drive, active high
- scan_done  out  1  one-cycle pulse when a full scan has been committed

## Operation
- Divider counts 0..SCAN_DIV-1 and wraps; a tick is issued at wrap.
- FSM states: IDLE, READ, CAPTURE, WAIT_COMMIT.
- IDLE: on tick, clear idx to 0 and go to READ.
- READ: drive ram_cs_n=0, ram_oe_n=0, ram_addr=BASE_ADDR+idx (truncated to ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH). Go to CAPTURE.
- CAPTURE: shadow[idx] <= ram_data[PWM_BITS-1:0]; cs_n/oe_n return high. If idx==LED_COUNT-1, go to WAIT_COMMIT; otherwise idx+1, then READ.
- WAIT_COMMIT: on the cycle pwm_cnt == all-ones, copy all shadow values into duty, pulse scan_done, and go to IDLE.
- Ticks arriving outside IDLE are dropped, not queued.
- PWM: pwm_cnt free-runs 0..2^PWM_BITS-1.
- led[i] = (pwm_cnt < duty[i]), except duty[i] all-ones, which gives constant 1.
- duty 0 gives constant 0.
- Upper data bits above PWM_BITS are ignored.

## Timing
- Reset values:
  - ram_cs_n=1, ram_oe_n=1, ram_we_n=1, ram_addr=0
  - led=0, scan_done=0
  - duty=0, shadow=0, idx=0, divider=0, pwm_cnt=0, FSM=IDLE
- RAM read latency is one cycle: data is sampled in CAPTURE, the cycle after READ.
- Each word takes 2 cycles; a scan occupies 2*LED_COUNT cycles, plus up to 2^PWM_BITS cycles in WAIT_COMMIT.
- All outputs are registered. led changes one cycle after pwm_cnt/duty change.
- New duty takes effect when pwm_cnt wraps to 0 following the commit cycle.
- Reset mid-scan: scan is aborted, shadow discarded, duty cleared, outputs return to reset values in the same edge.

## Configuration
- RAM_LED_PWM_EN defined: PWM behaviour as above.
- RAM_LED_PWM_EN undefined:
  - PWM counter omitted; led[i] = duty[i][0] (on/off from bit 0).
  - Commit occurs the cycle after the last CAPTURE (WAIT_COMMIT lasts one cycle).
  - All other behaviour unchanged.

## Test plan
- Reset: hold rst 3 cycles during a scan → all outputs at reset values; no cs_n low until first tick after release (SCAN_DIV cycles).
- Scan sequence: RAM words 0..3 = 0x0000, 0x0040, 0x0080, 0x00FF; SCAN_DIV=64 → ram_addr 0,1,2,3 in READ cycles, cs_n/oe_n low exactly 4 single cycles per scan, one scan_done.
- Duty check: after commit, count high cycles of led per 256-cycle period → 0, 64, 128, 256.
- Glitch-free commit: change word 1 from 0x0040 to 0x0020 mid-period → led[1] keeps 64-cycle high time until pwm_cnt wrap, then 32.
- Address wrap: BASE_ADDR=14, LED_COUNT=4 → addresses 14,15,0,1 read.
- Macro off: word 2 = 0x0003 → led[2] constant 1; word 2 = 0x0002 → led[2] constant 0 the cycle after next commit.
